// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall vector, registered flush pulse,
// multi-cycle EX sequencing (IDLE/BUSY/DONE) and a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int unsigned MC_W   = 6,
  parameter int unsigned PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              mc_start,
  input  logic [MC_W-1:0]   mc_len,
  input  logic              flush_req,
  output logic [5:0]        stall,
  output logic              flush,
  output logic              mc_busy,
  output logic              mc_done,
  output logic [PERF_W-1:0] stall_cnt
);

  localparam logic [MC_W-1:0]   McOne   = {{(MC_W-1){1'b0}}, 1'b1};
  localparam logic [PERF_W-1:0] PerfOne = {{(PERF_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic [MC_W-1:0]     cnt_q, cnt_d;
  logic                flush_q;
  logic [PERF_W-1:0]   stall_cnt_q;
  logic                accept;
  logic [MC_W-1:0]     load_val;

  // A new op is taken only outside BUSY, and never alongside a flush or reset.
  assign accept   = mc_start & ~flush_req & ~rst & (state_q != StBusy);
  // Zero length runs as a single-cycle op.
  assign load_val = (mc_len == '0) ? McOne : mc_len;

  // State, counter and flush registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_req;
    end
  end

  // Next-state and counter update; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StBusy;
          cnt_d   = load_val;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - McOne;
        if (cnt_q == McOne) state_d = StDone;
      end
      StDone: begin
        if (accept) begin
          state_d = StBusy;
          cnt_d   = load_val;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush_req) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  // Outputs: stall priority is flush, then EX hold, then ID bubble.
  always_comb begin
    mc_busy   = (state_q == StBusy) & ~rst;
    mc_done   = (state_q == StDone);
    flush     = flush_q;
    stall_cnt = stall_cnt_q;
    if (rst || flush_req) begin
      stall = 6'b000000;
    end else if (accept || mc_busy || stallreq_ex) begin
      stall = 6'b001111;
    end else if (stallreq_id) begin
      stall = 6'b000111;
    end else begin
      stall = 6'b000000;
    end
  end

  // Saturating count of cycles with any stage held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if ((stall != 6'b000000) && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + PerfOne;
    end
  end

endmodule
